key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Turns the two raw player push-buttons into clean one-cycle press pulses for
//  the tug-of-war playfield (drives its pressL/pressR inputs).
//  Each channel has a 2-flop synchronizer, a consecutive-sample debouncer and a
//  press FSM. Holding a key yields exactly one pulse.
//  A cross-channel arbiter drops simultaneous presses and flags them on tie.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive differing samples needed to accept a new level (>=1; 10 ms @ 50 MHz)
//  KEY_ACTIVE_LOW   1       1: raw key pressed = 0 (DE1 KEY); 0: pressed = 1
//  CW               $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//  clk     input   1  system clock (CLOCK_50)
//  reset   input   1  asynchronous, active-low reset (0 = in reset)
//  key_l   input   1  raw asynchronous left-player button
//  key_r   input   1  raw asynchronous right-player button
//  pressL  output  1  one-cycle registered left press pulse
//  pressR  output  1  one-cycle registered right press pulse
//  tie     output  1  one-cycle pulse: both presses accepted on the same edge, both dropped
//  held    output  2  {right,left} debounced pressed level, registered
// BEHAVIOUR
//  Reset (async assert, sync use on release): sync flops, stable levels and FSMs
//   are set to "released". cnt=0. pressL=pressR=tie=0. held=2'b00.
//  Normalise: pk = KEY_ACTIVE_LOW ? ~key : key. All logic below uses pk (1=pressed).
//  Synchronizer: s1<=pk, s2<=s1 on every edge. No other logic samples pk.
//  Debouncer, per channel, on each edge:
//   - s2==stable: cnt<=0.
//   - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
//   - otherwise: cnt<=cnt+1. Any single matching sample restarts the count.
//  Press FSM, per channel. States IDLE, DOWN:
//   - IDLE, stable=1: go to DOWN and raise the raw request for this edge.
//   - DOWN, stable=0: go to IDLE. No request.
//   - All other cases hold state. A held key never re-fires.
//  Arbiter, registered outputs:
//   - only reqL: pressL<=1.
//   - only reqR: pressR<=1.
//   - both on the same edge: pressL<=0, pressR<=0, tie<=1.
//   - Both FSMs still enter DOWN, so neither player re-fires until released.
//   - All pulses are high for exactly one cycle.
//  held <= {stable_r, stable_l}.
//  Latency: count edge 1 as the first edge that samples a new key level, with
//   the level then constant. The pulse goes high after edge DEBOUNCE_CYCLES+3
//   and low after the next edge.
//  Bounce: any toggle shorter than DEBOUNCE_CYCLES samples produces no pulse
//   and no held change.
//  Release: debounced the same way. It produces no pulse. Only the
//   release-to-press transition pulses.
//  Key held through reset release: the channel starts "released", so it fires
//   one pulse DEBOUNCE_CYCLES+3 edges after reset deasserts.
//  Reset mid-debounce or mid-pulse: the pulse drops immediately (async) and the
//   partial count is discarded.
//  Channels are independent except for the arbiter. Presses in adjacent cycles
//   both pass.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
//  T1 Reset: reset=0 for 2 cycles with keys=1, then 1 -> all outputs 0 and no
//   pulse for 20 cycles.
//  T2 Clean press: key_l 1->0 and held for 30 cycles -> pressL=1 for exactly one
//   cycle, after edge 7. held[0]=1 from edge 7 onward. pressR=tie=0 throughout.
//  T3 Bounce: key_r pattern 0,0,0,1,0,0,0,1,1 then steady 0 -> no pulse during
//   the glitches. A single pressR pulse 7 edges after the steady 0 begins.
//  T4 Hold and re-press: hold key_l 50 cycles, release 10, press again -> exactly
//   2 pressL pulses. None on release.
//  T5 Tie: key_l and key_r fall on the same cycle -> tie=1 for one cycle after
//   edge 7, pressL=pressR=0. Release both, then press only key_r -> one pressR.
//  T6 Reset mid-op: assert reset 3 edges into a key_l debounce -> pressL stays 0.
//   Key still low after reset release -> one pressL 7 edges later.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronize, debounce and edge-detect two player keys into one-cycle press pulses
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l,
  input  logic       key_r,
  output logic       pressL,
  output logic       pressR,
  output logic       tie,
  output logic [1:0] held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, DOWN} state_t;
  logic [1:0] pk, s1_q, s2_q, stable_q, stable_d, req;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  state_t state_q [2];
  state_t state_d [2];
  logic press_l_q, press_l_d, press_r_q, press_r_d, tie_q, tie_d;
  logic [1:0] held_q;
  assign pk = KEY_ACTIVE_LOW ? ~{key_r, key_l} : {key_r, key_l};
  // Per channel: restart count on any matching sample, accept after LAST+1 differing ones; fire on IDLE->DOWN
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = (s2_q[i] == stable_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == LAST) ? s2_q[i] : stable_q[i];
      req[i]      = state_q[i] == IDLE && stable_q[i];
      state_d[i]  = req[i] ? DOWN : (state_q[i] == DOWN && !stable_q[i]) ? IDLE : state_q[i];
    end
  end
  // Arbiter: a lone request passes, simultaneous requests are both dropped and reported as a tie
  always_comb begin
    press_l_d = req[0] & ~req[1];
    press_r_d = req[1] & ~req[0];
    tie_d     = &req;
  end
  // State registers; reset puts every channel in the released state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      state_q   <= '{IDLE, IDLE};
      press_l_q <= 1'b0;
      press_r_q <= 1'b0;
      tie_q     <= 1'b0;
      held_q    <= '0;
    end else begin
      s1_q      <= pk;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_l_q <= press_l_d;
      press_r_q <= press_r_d;
      tie_q     <= tie_d;
      held_q    <= stable_q;
    end
  end
  assign pressL = press_l_q;
  assign pressR = press_r_q;
  assign tie    = tie_q;
  assign held   = held_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed per-cycle scoreboard check of key_conditioner with DEBOUNCE_CYCLES=4
module tb_key_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_l = 1'b1;
  logic key_r = 1'b1;
  logic pressL, pressR, tie;
  logic [1:0] held;
  int errors = 0;
  int checks = 0;
  logic [4:0] sb [$];
  logic pat [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  key_conditioner #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
    .pressL(pressL), .pressR(pressR), .tie(tie), .held(held)
  );

  always #5 clk = ~clk;

  // Observed vector: {tie, pressR, pressL, held[1], held[0]}
  function automatic logic [4:0] obs();
    return {tie, pressR, pressL, held};
  endfunction

  task automatic check(input string tag, input logic [4:0] exp);
    checks++;
    assert (obs() === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs(), exp);
    end
  endtask

  // Drive keys for one cycle, queue the expectation for the next edge, then compare
  task automatic step(input string tag, input logic kl, input logic kr, input logic [4:0] exp);
    key_l = kl;
    key_r = kr;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, sb.pop_front());
  endtask

  // Hold keys for n cycles; pulse bits expected only at step pulse_at, held flips at step 7
  task automatic run(input string tag, input logic kl, input logic kr, input int n, input int pulse_at,
                     input logic [2:0] pulse, input logic [1:0] h_before, input logic [1:0] h_after);
    for (int i = 1; i <= n; i++)
      step(tag, kl, kr, {(i == pulse_at) ? pulse : 3'b000, (i >= 7) ? h_after : h_before});
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    // T1 reset
    step("t1_in_reset", 1, 1, 5'b0);
    step("t1_in_reset", 1, 1, 5'b0);
    reset = 1'b1;
    run("t1_idle", 1, 1, 20, 0, 3'b000, 2'b00, 2'b00);
    // T2 clean press and release
    run("t2_press", 0, 1, 30, 7, 3'b001, 2'b00, 2'b01);
    run("t2_release", 1, 1, 10, 0, 3'b000, 2'b01, 2'b00);
    // T3 bounce on key_r, then steady press
    for (int i = 0; i < 9; i++) step("t3_bounce", 1, pat[i], 5'b0);
    run("t3_steady", 1, 0, 20, 7, 3'b010, 2'b00, 2'b10);
    run("t3_release", 1, 1, 10, 0, 3'b000, 2'b10, 2'b00);
    // T4 long hold, release, re-press
    run("t4_hold", 0, 1, 50, 7, 3'b001, 2'b00, 2'b01);
    run("t4_release", 1, 1, 10, 0, 3'b000, 2'b01, 2'b00);
    run("t4_repress", 0, 1, 20, 7, 3'b001, 2'b00, 2'b01);
    run("t4_release2", 1, 1, 10, 0, 3'b000, 2'b01, 2'b00);
    // T5 tie, then a lone right press
    run("t5_tie", 0, 0, 20, 7, 3'b100, 2'b00, 2'b11);
    run("t5_release", 1, 1, 10, 0, 3'b000, 2'b11, 2'b00);
    run("t5_right", 1, 0, 20, 7, 3'b010, 2'b00, 2'b10);
    run("t5_release2", 1, 1, 10, 0, 3'b000, 2'b10, 2'b00);
    // T7 presses one cycle apart both pass
    step("t7_adjacent", 0, 1, 5'b0);
    for (int i = 2; i <= 20; i++)
      step("t7_adjacent", 0, 0, {1'b0, i == 8, i == 7, i >= 8, i >= 7});
    run("t7_release", 1, 1, 10, 0, 3'b000, 2'b11, 2'b00);
    // T6 reset mid-debounce, then mid-pulse
    for (int i = 0; i < 3; i++) step("t6_debounce", 0, 1, 5'b0);
    reset = 1'b0;
    #1;
    check("t6_async_reset", 5'b0);
    step("t6_in_reset", 0, 1, 5'b0);
    step("t6_in_reset", 0, 1, 5'b0);
    reset = 1'b1;
    run("t6_after_reset", 0, 1, 7, 7, 3'b001, 2'b00, 2'b01);
    reset = 1'b0;
    #1;
    check("t6_pulse_drop", 5'b0);
    step("t6_in_reset2", 0, 1, 5'b0);
    reset = 1'b1;
    run("t6_after_reset2", 0, 1, 20, 7, 3'b001, 2'b00, 2'b01);
    run("t6_release", 1, 1, 10, 0, 3'b000, 2'b01, 2'b00);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
